psg_bus_sched: RTL

PSG_BUS_SCHED -- requirements
Module: psg_bus_sched

---
 rtl/psg_bus_pkg.sv | 35 +++
 rtl/psg_strobe_timer.sv | 41 ++++
 rtl/psg_bus_sched.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/psg_bus_pkg.sv
// rtl/psg_bus_pkg.sv - shared states, bus phase codes and request types for psg_bus_sched
package psg_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CPU_ADDR,
        ST_CPU_WR,
        ST_CPU_RD,
        ST_AUX_SEL,
        ST_AUX_ADDR,
        ST_AUX_WR,
        ST_RST_SEL,
        ST_RST_ADDR
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_ADDR,
        REQ_DATA,
        REQ_READ
    } req_t;

    // Bus phase codes as {BDIR, BC}
    localparam logic [1:0] PH_INACTIVE = 2'b00;
    localparam logic [1:0] PH_ADDR     = 2'b11;
    localparam logic [1:0] PH_WRITE    = 2'b10;
    localparam logic [1:0] PH_READ     = 2'b01;

    localparam logic [6:0] CHIP_SEL_PREFIX = 7'b1111111;

    function automatic logic is_chip_sel(input logic [7:0] v);
        return v[7:1] == CHIP_SEL_PREFIX;
    endfunction

endpackage

// File: rtl/psg_strobe_timer.sv
// rtl/psg_strobe_timer.sv - times one bus phase: STROBE_CYC active cycles then one gap cycle
module psg_strobe_timer #(
    parameter int STROBE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic active,
    output logic phase_last,
    output logic phase_done
);

    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYC - 1);
    localparam logic [3:0] GAP_CNT  = 4'(STROBE_CYC);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Restarting at the gap lets the scheduler chain phases back to back
    always_comb begin
        cnt_d = cnt_q;
        if (!run || cnt_q == GAP_CNT) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active     = run && (cnt_q < GAP_CNT);
    assign phase_last = run && (cnt_q == LAST_CNT);
    assign phase_done = run && (cnt_q == GAP_CNT);

endmodule

// File: rtl/psg_bus_sched.sv
// rtl/psg_bus_sched.sv - CPU/aux arbiter for a TurboSound PSG pair bus; aux path under PSG_AUX_PORT_EN
module psg_bus_sched
    import psg_bus_pkg::*;
#(
    parameter int STROBE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_ADDR_WR,
    input  logic       CPU_DATA_WR,
    input  logic       CPU_RD,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_RD_VALID,
    output logic       CPU_WAIT,
    input  logic       AUX_REQ,
    output logic       AUX_ACK,
    input  logic       AUX_CHIP,
    input  logic [3:0] AUX_REG,
    input  logic [7:0] AUX_DATA,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO
);

    state_t     state_q, state_d;
    req_t       slot_type_q, slot_type_d;
    logic [7:0] slot_data_q, slot_data_d;
    logic       cpu_sel_q, cpu_sel_d;
    logic [3:0] cpu_reg_q, cpu_reg_d;
    logic [7:0] psg_di_q, psg_di_d;
    logic [7:0] cpu_do_q, cpu_do_d;
    logic       rd_valid_q, rd_valid_d;

    logic       tm_active;
    logic       tm_last;
    logic       tm_done;
    logic [1:0] phase;
    logic [7:0] drive;
    logic       slot_clear;
`ifdef PSG_AUX_PORT_EN
    logic       aux_ack;
`else
    logic       aux_unused;
`endif

    psg_strobe_timer #(
        .STROBE_CYC (STROBE_CYC)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .run        (state_q != ST_IDLE),
        .active     (tm_active),
        .phase_last (tm_last),
        .phase_done (tm_done)
    );

    always_comb begin
        state_d     = state_q;
        slot_type_d = slot_type_q;
        slot_data_d = slot_data_q;
        cpu_sel_d   = cpu_sel_q;
        cpu_reg_d   = cpu_reg_q;
        cpu_do_d    = cpu_do_q;
        rd_valid_d  = 1'b0;
        phase       = PH_INACTIVE;
        drive       = psg_di_q;
        slot_clear  = 1'b0;
`ifdef PSG_AUX_PORT_EN
        aux_ack     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (slot_type_q == REQ_ADDR) begin
                    state_d = ST_CPU_ADDR;
                end else if (slot_type_q == REQ_DATA) begin
                    state_d = ST_CPU_WR;
                end else if (slot_type_q == REQ_READ) begin
                    state_d = ST_CPU_RD;
`ifdef PSG_AUX_PORT_EN
                end else if (AUX_REQ) begin
                    state_d = ST_AUX_SEL;
`endif
                end
            end
            ST_CPU_ADDR: begin
                phase = PH_ADDR;
                drive = slot_data_q;
                if (tm_done) begin
                    state_d    = ST_IDLE;
                    slot_clear = 1'b1;
                    if (is_chip_sel(slot_data_q)) begin
                        cpu_sel_d = slot_data_q[0];
                    end else begin
                        cpu_reg_d = slot_data_q[3:0];
                    end
                end
            end
            ST_CPU_WR: begin
                phase = PH_WRITE;
                drive = slot_data_q;
                if (tm_done) begin
                    state_d    = ST_IDLE;
                    slot_clear = 1'b1;
                end
            end
            ST_CPU_RD: begin
                phase = PH_READ;
                if (tm_last) begin
                    cpu_do_d   = PSG_DO;
                    rd_valid_d = 1'b1;
                end
                if (tm_done) begin
                    state_d    = ST_IDLE;
                    slot_clear = 1'b1;
                end
            end
`ifdef PSG_AUX_PORT_EN
            ST_AUX_SEL: begin
                phase = PH_ADDR;
                drive = {CHIP_SEL_PREFIX, AUX_CHIP};
                if (tm_done) state_d = ST_AUX_ADDR;
            end
            ST_AUX_ADDR: begin
                phase = PH_ADDR;
                drive = {4'h0, AUX_REG};
                if (tm_done) state_d = ST_AUX_WR;
            end
            ST_AUX_WR: begin
                phase = PH_WRITE;
                drive = AUX_DATA;
                if (tm_done) begin
                    state_d = ST_RST_SEL;
                    aux_ack = 1'b1;
                end
            end
            // Put the chip/register selection back where the CPU left it
            ST_RST_SEL: begin
                phase = PH_ADDR;
                drive = {CHIP_SEL_PREFIX, cpu_sel_q};
                if (tm_done) state_d = ST_RST_ADDR;
            end
            ST_RST_ADDR: begin
                phase = PH_ADDR;
                drive = {4'h0, cpu_reg_q};
                if (tm_done) state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!tm_active) begin
            phase = PH_INACTIVE;
        end
        psg_di_d = tm_active ? drive : psg_di_q;

        // The slot only accepts while empty; a clearing slot still counts as full
        if (slot_clear) begin
            slot_type_d = REQ_NONE;
        end
        if (slot_type_q == REQ_NONE) begin
            if (CPU_ADDR_WR) begin
                slot_type_d = REQ_ADDR;
                slot_data_d = CPU_DI;
            end else if (CPU_DATA_WR) begin
                slot_type_d = REQ_DATA;
                slot_data_d = CPU_DI;
            end else if (CPU_RD) begin
                slot_type_d = REQ_READ;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            slot_type_q <= REQ_NONE;
            slot_data_q <= 8'h00;
            cpu_sel_q   <= 1'b1;
            cpu_reg_q   <= 4'h0;
            psg_di_q    <= 8'h00;
            cpu_do_q    <= 8'hFF;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_type_q <= slot_type_d;
            slot_data_q <= slot_data_d;
            cpu_sel_q   <= cpu_sel_d;
            cpu_reg_q   <= cpu_reg_d;
            psg_di_q    <= psg_di_d;
            cpu_do_q    <= cpu_do_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign PSG_BDIR     = phase[1];
    assign PSG_BC       = phase[0];
    assign PSG_DI       = psg_di_d;
    assign CPU_DO       = cpu_do_q;
    assign CPU_RD_VALID = rd_valid_q;
    assign CPU_WAIT     = (slot_type_q != REQ_NONE);
`ifdef PSG_AUX_PORT_EN
    assign AUX_ACK      = aux_ack;
`else
    assign AUX_ACK      = 1'b0;
    assign aux_unused   = ^{AUX_REQ, AUX_CHIP, AUX_REG, AUX_DATA};
`endif

endmodule
